phy_src_arbiter: RTL and testbench

//  Sequences ownership of the PHY packet path between the initializer, calibration

---
 rtl/phy_src_arbiter_if.sv | 55 +++++
 rtl/phy_src_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_phy_src_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/phy_src_arbiter_if.sv
// ----------------------------------------------------------------------------
// phy_src_arbiter_if
//  Bundles the signals of the PHY packet-path arbiter: the three packet sources
//  (initializer, calibration handler, scheduler), the ownership handshakes and
//  the registered output stream.
//  modport slave  : the arbiter's view (sources in, grant/hold/stream out)
//  modport master : the view of the surrounding logic that feeds the arbiter
//                   and consumes its output
//  Parameters: PKT_W packet width, CMD_W command width.
// ----------------------------------------------------------------------------
interface phy_src_arbiter_if #(
  parameter int PKT_W = 512,
  parameter int CMD_W = 4
);
  logic             init_done;
  logic [PKT_W-1:0] init_pkt;
  logic [CMD_W-1:0] init_cmd;
  logic             init_pkt_valid;

  logic [PKT_W-1:0] sched_pkt;
  logic [CMD_W-1:0] sched_cmd;
  logic             sched_pkt_valid;
  logic             sched_hold;

  logic             cal_req;
  logic             cal_gnt;
  logic [PKT_W-1:0] cal_pkt;
  logic [CMD_W-1:0] cal_cmd;
  logic             cal_pkt_valid;
  logic             cal_release;

  logic [PKT_W-1:0] out_pkt;
  logic [CMD_W-1:0] out_cmd;
  logic             out_pkt_valid;
  logic [1:0]       out_src;
  logic             cal_timeout;

  modport slave (
    input  init_done, init_pkt, init_cmd, init_pkt_valid,
    input  sched_pkt, sched_cmd, sched_pkt_valid,
    output sched_hold,
    input  cal_req, cal_pkt, cal_cmd, cal_pkt_valid, cal_release,
    output cal_gnt,
    output out_pkt, out_cmd, out_pkt_valid, out_src, cal_timeout
  );

  modport master (
    output init_done, init_pkt, init_cmd, init_pkt_valid,
    output sched_pkt, sched_cmd, sched_pkt_valid,
    input  sched_hold,
    output cal_req, cal_pkt, cal_cmd, cal_pkt_valid, cal_release,
    input  cal_gnt,
    input  out_pkt, out_cmd, out_pkt_valid, out_src, cal_timeout
  );
endinterface

// File: rtl/phy_src_arbiter.sv
// ----------------------------------------------------------------------------
// phy_src_arbiter
//  Hands ownership of the PHY packet path between initializer, calibration
//  handler and scheduler, including run-time recalibration: the scheduler is
//  held off, its outstanding traffic drained, the cal handler granted and the
//  path returned. The output is a single registered packet stream.
//
//  Ports:
//   clk_div    PHY divided clock (sole clock)
//   rst_div_n  asynchronous active-low reset
//   bus        phy_src_arbiter_if.slave - sources, sched_hold/cal_gnt,
//              out_pkt/out_cmd/out_pkt_valid/out_src, cal_timeout
//
//  Optional feature: define ARB_TIMEOUT_EN to bound a run-time calibration
//  grant to CAL_TMO_CYC cycles (forced release with a cal_timeout pulse).
//  Without it cal_timeout is tied low and CALR waits for cal_release.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_INIT  | initializer owns path, waiting for init_done
//  ST_CAL0  | post-init calibration, cal handler owns path
//  ST_SCHED | normal operation, scheduler owns path
//  ST_DRAIN | scheduler held, waiting for DRAIN_CYC idle cycles
//  ST_CALR  | run-time calibration, cal handler owns path
// ----------------------------------------------------------------------------
module phy_src_arbiter #(
  parameter int PKT_W       = 512,
  parameter int CMD_W       = 4,
  parameter int DRAIN_CYC   = 16,
  parameter int CAL_TMO_CYC = 4096
) (
  input logic               clk_div,
  input logic               rst_div_n,
  phy_src_arbiter_if.slave  bus
);

  // $clog2(1) is 0, so keep at least one bit for the DRAIN_CYC=0 case
  localparam int DRN_W = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYC);

  localparam logic [1:0] SRC_INIT  = 2'd0;
  localparam logic [1:0] SRC_CAL   = 2'd1;
  localparam logic [1:0] SRC_SCHED = 2'd2;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_CAL0  = 3'd1,
    ST_SCHED = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CALR  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [DRN_W-1:0] drn_cnt, drn_cnt_nxt;
  logic             tmo_fire;

  logic             sched_hold_q;
  logic             cal_gnt_q;
  logic             cal_timeout_q;

  logic             fwd_valid;
  logic [PKT_W-1:0] fwd_pkt;
  logic [CMD_W-1:0] fwd_cmd;
  logic [1:0]       fwd_src;

  logic [PKT_W-1:0] out_pkt_q;
  logic [CMD_W-1:0] out_cmd_q;
  logic             out_valid_q;
  logic [1:0]       out_src_q;

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = (CAL_TMO_CYC > 0) ? $clog2(CAL_TMO_CYC + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(CAL_TMO_CYC);

  // Down-counter loaded on CALR entry; expiry is taken when it reaches its
  // last cycle so the forced release lands CAL_TMO_CYC cycles after entry.
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             tmo_done;

  assign tmo_done = (tmo_cnt <= TMO_W'(1));
`else
  logic             tmo_done;

  assign tmo_done = 1'b0;
`endif

  // Next-state, drain counter and timeout decision
  always_comb begin
    state_nxt   = state;
    drn_cnt_nxt = '0;
    tmo_fire    = 1'b0;

    unique case (state)
      ST_INIT: begin
        if (bus.init_done) state_nxt = ST_CAL0;
      end
      ST_CAL0: begin
        if (bus.cal_release) state_nxt = ST_SCHED;
      end
      ST_SCHED: begin
        if (bus.cal_req) begin
          state_nxt   = ST_DRAIN;
          drn_cnt_nxt = DRN_LOAD;
        end
      end
      ST_DRAIN: begin
        // abort takes priority; a late scheduler beat restarts the idle window
        if (!bus.cal_req) begin
          state_nxt = ST_SCHED;
        end else if (bus.sched_pkt_valid) begin
          drn_cnt_nxt = DRN_LOAD;
        end else if (drn_cnt == '0) begin
          state_nxt = ST_CALR;
        end else begin
          drn_cnt_nxt = drn_cnt - DRN_W'(1);
        end
      end
      ST_CALR: begin
        if (bus.cal_release) begin
          state_nxt = ST_SCHED;
        end else if (tmo_done) begin
          state_nxt = ST_SCHED;
          tmo_fire  = 1'b1;
        end
      end
      default: state_nxt = ST_INIT;
    endcase

    // loss of init_done overrides everything and clears the counters
    if (!bus.init_done) begin
      state_nxt   = ST_INIT;
      drn_cnt_nxt = '0;
      tmo_fire    = 1'b0;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_comb begin
    tmo_cnt_nxt = '0;
    if (state_nxt == ST_CALR) begin
      if (state != ST_CALR) tmo_cnt_nxt = TMO_LOAD;
      else if (tmo_cnt != '0) tmo_cnt_nxt = tmo_cnt - TMO_W'(1);
    end
  end

  always_ff @(posedge clk_div or negedge rst_div_n) begin
    if (!rst_div_n) tmo_cnt <= '0;
    else            tmo_cnt <= tmo_cnt_nxt;
  end
`endif

  // State register; hold/grant are registered from next-state so they move
  // on the same edge as the state itself
  always_ff @(posedge clk_div or negedge rst_div_n) begin
    if (!rst_div_n) begin
      state         <= ST_INIT;
      drn_cnt       <= '0;
      sched_hold_q  <= 1'b1;
      cal_gnt_q     <= 1'b0;
      cal_timeout_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      drn_cnt       <= drn_cnt_nxt;
      sched_hold_q  <= (state_nxt != ST_SCHED);
      cal_gnt_q     <= (state_nxt == ST_CAL0) || (state_nxt == ST_CALR);
      cal_timeout_q <= tmo_fire;
    end
  end

  // Source select follows the owner in the sampling cycle; the scheduler
  // still owns the path in DRAIN because it reacts to sched_hold one cycle late
  always_comb begin
    fwd_valid = 1'b0;
    fwd_pkt   = bus.init_pkt;
    fwd_cmd   = bus.init_cmd;
    fwd_src   = SRC_INIT;
    unique case (state)
      ST_CAL0, ST_CALR: begin
        fwd_valid = bus.cal_pkt_valid;
        fwd_pkt   = bus.cal_pkt;
        fwd_cmd   = bus.cal_cmd;
        fwd_src   = SRC_CAL;
      end
      ST_SCHED, ST_DRAIN: begin
        fwd_valid = bus.sched_pkt_valid;
        fwd_pkt   = bus.sched_pkt;
        fwd_cmd   = bus.sched_cmd;
        fwd_src   = SRC_SCHED;
      end
      default: begin
        fwd_valid = bus.init_pkt_valid;
      end
    endcase
  end

  always_ff @(posedge clk_div or negedge rst_div_n) begin
    if (!rst_div_n) begin
      out_pkt_q   <= '0;
      out_cmd_q   <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= SRC_INIT;
    end else begin
      out_valid_q <= fwd_valid;
      if (fwd_valid) begin
        out_pkt_q <= fwd_pkt;
        out_cmd_q <= fwd_cmd;
        out_src_q <= fwd_src;
      end
    end
  end

  assign bus.sched_hold    = sched_hold_q;
  assign bus.cal_gnt       = cal_gnt_q;
  assign bus.cal_timeout   = cal_timeout_q;
  assign bus.out_pkt       = out_pkt_q;
  assign bus.out_cmd       = out_cmd_q;
  assign bus.out_pkt_valid = out_valid_q;
  assign bus.out_src       = out_src_q;

endmodule

// File: tb/tb_phy_src_arbiter.sv
// ----------------------------------------------------------------------------
// tb_phy_src_arbiter
//  Directed bench for phy_src_arbiter with DRAIN_CYC=4, CAL_TMO_CYC=8.
//  Inputs change 1 time unit after the rising edge; outputs are checked at the
//  same point, i.e. they reflect the edge just taken.
// ----------------------------------------------------------------------------
module tb_phy_src_arbiter;
  localparam int PKT_W = 32;
  localparam int CMD_W = 4;

  logic clk_div;
  logic rst_div_n;
  int   n_cmp;
  int   n_bad;

  phy_src_arbiter_if #(.PKT_W(PKT_W), .CMD_W(CMD_W)) bus ();

  phy_src_arbiter #(
    .PKT_W(PKT_W), .CMD_W(CMD_W), .DRAIN_CYC(4), .CAL_TMO_CYC(8)
  ) dut (
    .clk_div  (clk_div),
    .rst_div_n(rst_div_n),
    .bus      (bus)
  );

  initial begin
    clk_div = 1'b0;
    forever #5 clk_div = ~clk_div;
  end

  task automatic step();
    @(posedge clk_div);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_div_n           = 1'b0;
    bus.init_done       = 1'b0;
    bus.init_pkt        = '0;
    bus.init_cmd        = '0;
    bus.init_pkt_valid  = 1'b0;
    bus.sched_pkt       = '0;
    bus.sched_cmd       = '0;
    bus.sched_pkt_valid = 1'b0;
    bus.cal_req         = 1'b0;
    bus.cal_pkt         = '0;
    bus.cal_cmd         = '0;
    bus.cal_pkt_valid   = 1'b0;
    bus.cal_release     = 1'b0;

    repeat (2) step();
    chk("rst_sched_hold", bus.sched_hold, 1);
    chk("rst_cal_gnt", bus.cal_gnt, 0);
    chk("rst_out_valid", bus.out_pkt_valid, 0);
    chk("rst_out_pkt", bus.out_pkt, 0);
    chk("rst_out_src", bus.out_src, 0);
    chk("rst_cal_timeout", bus.cal_timeout, 0);
    rst_div_n = 1'b1;

    // init beat forwarded, simultaneous sched beat dropped
    bus.init_pkt = 32'hA5; bus.init_cmd = 4'h1; bus.init_pkt_valid = 1'b1;
    bus.sched_pkt = 32'hFF; bus.sched_pkt_valid = 1'b1;
    step();
    chk("init_out_pkt", bus.out_pkt, 32'hA5);
    chk("init_out_cmd", bus.out_cmd, 4'h1);
    chk("init_out_src", bus.out_src, 0);
    chk("init_out_valid", bus.out_pkt_valid, 1);

    bus.init_pkt_valid = 1'b0;
    step();
    chk("sched_drop_valid", bus.out_pkt_valid, 0);
    chk("sched_drop_hold_pkt", bus.out_pkt, 32'hA5);

    // init_done -> CAL0
    bus.sched_pkt_valid = 1'b0;
    bus.init_done = 1'b1;
    step();
    chk("cal0_gnt", bus.cal_gnt, 1);
    chk("cal0_hold", bus.sched_hold, 1);

    // cal beat and release in the same cycle; sched beat in same cycle dropped
    bus.cal_pkt = 32'h3C; bus.cal_cmd = 4'h2; bus.cal_pkt_valid = 1'b1;
    bus.cal_release = 1'b1;
    bus.sched_pkt = 32'h77; bus.sched_cmd = 4'h3; bus.sched_pkt_valid = 1'b1;
    step();
    chk("cal0_out_pkt", bus.out_pkt, 32'h3C);
    chk("cal0_out_cmd", bus.out_cmd, 4'h2);
    chk("cal0_out_src", bus.out_src, 1);
    chk("cal0_rel_gnt", bus.cal_gnt, 0);
    chk("cal0_rel_hold", bus.sched_hold, 0);

    bus.cal_pkt_valid = 1'b0; bus.cal_release = 1'b0;
    step();
    chk("sched_out_pkt", bus.out_pkt, 32'h77);
    chk("sched_out_cmd", bus.out_cmd, 4'h3);
    chk("sched_out_src", bus.out_src, 2);
    chk("sched_out_valid", bus.out_pkt_valid, 1);

    // cal beat while scheduler owns path is dropped
    bus.sched_pkt_valid = 1'b0;
    bus.cal_pkt = 32'h11; bus.cal_pkt_valid = 1'b1;
    step();
    chk("cal_drop_valid", bus.out_pkt_valid, 0);
    chk("cal_drop_pkt", bus.out_pkt, 32'h77);

    // run-time cal with one late sched beat in the first DRAIN cycle
    bus.cal_pkt_valid = 1'b0;
    bus.cal_req = 1'b1;
    step();
    chk("drain_hold", bus.sched_hold, 1);
    chk("drain_gnt0", bus.cal_gnt, 0);
    bus.sched_pkt = 32'h5A; bus.sched_pkt_valid = 1'b1;
    step();
    chk("drain_fwd_pkt", bus.out_pkt, 32'h5A);
    chk("drain_fwd_src", bus.out_src, 2);
    chk("drain_fwd_valid", bus.out_pkt_valid, 1);
    chk("drain_gnt1", bus.cal_gnt, 0);
    bus.sched_pkt_valid = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      step();
      chk($sformatf("drain_wait_gnt_c%0d", i), bus.cal_gnt, 0);
    end
    step();
    chk("calr_gnt_c6", bus.cal_gnt, 1);
    chk("calr_hold_c6", bus.sched_hold, 1);

    // cal_req low is ignored in CALR; cal beat forwarded
    bus.cal_req = 1'b0;
    bus.cal_pkt = 32'h3D; bus.cal_pkt_valid = 1'b1;
    step();
    chk("calr_out_pkt", bus.out_pkt, 32'h3D);
    chk("calr_out_src", bus.out_src, 1);
    chk("calr_req_ignored_gnt", bus.cal_gnt, 1);

    bus.cal_pkt_valid = 1'b0; bus.cal_release = 1'b1;
    step();
    chk("calr_rel_gnt", bus.cal_gnt, 0);
    chk("calr_rel_hold", bus.sched_hold, 0);
    bus.cal_release = 1'b0;

    // drain abort after two cycles
    bus.cal_req = 1'b1;
    step();
    chk("abort_hold_c0", bus.sched_hold, 1);
    step();
    chk("abort_gnt_c1", bus.cal_gnt, 0);
    bus.cal_req = 1'b0;
    step();
    chk("abort_hold_c2", bus.sched_hold, 0);
    chk("abort_gnt_c2", bus.cal_gnt, 0);
    step();
    chk("abort_gnt_c3", bus.cal_gnt, 0);
    chk("abort_hold_c3", bus.sched_hold, 0);

    // idle drain (DRAIN_CYC+1 cycles), then init_done falls in CALR
    bus.cal_req = 1'b1;
    step();
    repeat (4) step();
    chk("idle_drain_gnt_early", bus.cal_gnt, 0);
    step();
    chk("idle_drain_gnt_c5", bus.cal_gnt, 1);
    bus.cal_req = 1'b0;
    bus.init_done = 1'b0;
    step();
    chk("initfall_gnt", bus.cal_gnt, 0);
    chk("initfall_hold", bus.sched_hold, 1);
    bus.cal_pkt = 32'h99; bus.cal_pkt_valid = 1'b1;
    step();
    chk("initfall_cal_drop_valid", bus.out_pkt_valid, 0);
    chk("initfall_cal_drop_pkt", bus.out_pkt, 32'h3D);
    chk("initfall_gnt_stays", bus.cal_gnt, 0);

    // back through CAL0 and SCHED into a fresh CALR
    bus.cal_pkt_valid = 1'b0;
    bus.init_done = 1'b1;
    step();
    chk("recal0_gnt", bus.cal_gnt, 1);
    bus.cal_release = 1'b1;
    step();
    chk("resched_hold", bus.sched_hold, 0);
    bus.cal_release = 1'b0;
    bus.cal_req = 1'b1;
    step();
    repeat (4) step();
    step();
    chk("calr2_gnt_t0", bus.cal_gnt, 1);
    bus.cal_req = 1'b0;

`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("tmo_gnt_t%0d", i), bus.cal_gnt, 1);
      chk($sformatf("tmo_pulse_t%0d", i), bus.cal_timeout, 0);
    end
    step();
    chk("tmo_pulse_t8", bus.cal_timeout, 1);
    chk("tmo_gnt_t8", bus.cal_gnt, 0);
    chk("tmo_hold_t8", bus.sched_hold, 0);
    step();
    chk("tmo_pulse_t9", bus.cal_timeout, 0);
`else
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("notmo_gnt_t%0d", i), bus.cal_gnt, 1);
      chk($sformatf("notmo_pulse_t%0d", i), bus.cal_timeout, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
